// File: rtl/rtc_edit_ctrl.sv
// RTC edit/write sequencer: six editable time/date fields with a cursor,
// BCD field streaming and a fixed RTC init sequence over req/ack.
module rtc_edit_ctrl #(
  parameter logic [7:0] BASE_ADDR  = 8'h21,
  parameter logic [7:0] INIT_ADDR  = 8'h02,
  parameter logic [7:0] INIT_DATA0 = 8'h10,
  parameter logic [7:0] INIT_DATA1 = 8'h00
) (
  input  logic       clk,
  input  logic       btn_reset,
  input  logic       inc_p,
  input  logic       dec_p,
  input  logic       right_p,
  input  logic       left_p,
  input  logic       escrib,
  input  logic       sw_conf,
  input  logic       doce_24,
  input  logic       init_sw,
  input  logic       wr_ack,
  output logic       wr_req,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       done_p,
  output logic [2:0] cursor,
  output logic [6:0] cur_val
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WREQ,
    S_WGAP,
    S_IREQ0,
    S_IGAP,
    S_IREQ1,
    S_DONE
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [6:0] r_field [6];
  logic [2:0] r_cursor;
  logic [2:0] r_idx;
  logic       r_esc_cur;
  logic       r_esc_prev;
  logic       r_ini_cur;
  logic       r_ini_prev;

  logic       w_esc_rise;
  logic       w_ini_rise;
  logic       w_edit;
  logic       w_inc;
  logic       w_dec;
  logic       w_right;
  logic       w_left;
  logic       w_fix12;
  logic [6:0] w_lo;
  logic [6:0] w_hi;
  logic [6:0] w_cur;
  logic [6:0] w_wval;
  logic [7:0] w_bcd;

  assign w_esc_rise = r_esc_cur & ~r_esc_prev;
  assign w_ini_rise = r_ini_cur & ~r_ini_prev;

  assign w_edit  = (r_state == S_IDLE) & sw_conf;
  assign w_inc   = w_edit & inc_p & ~dec_p;
  assign w_dec   = w_edit & dec_p & ~inc_p;
  assign w_right = w_edit & right_p & ~left_p;
  assign w_left  = w_edit & left_p & ~right_p;

  assign w_cur   = r_field[r_cursor];
  assign w_fix12 = doce_24 &
                   ((r_field[2] == 7'd0) |
                    (r_field[2] > 7'd12));

  assign w_wval = r_field[r_idx];
  assign w_bcd  = {4'(w_wval / 7'd10),
                   4'(w_wval % 7'd10)};

  assign busy    = (r_state != S_IDLE);
  assign done_p  = (r_state == S_DONE);
  assign cursor  = r_cursor;
  assign cur_val = w_cur;

  always_comb begin
    w_lo = 7'd0;
    w_hi = 7'd59;
    case (r_cursor)
      3'd2: begin
        w_lo = doce_24 ? 7'd1 : 7'd0;
        w_hi = doce_24 ? 7'd12 : 7'd23;
      end
      3'd3: begin
        w_lo = 7'd1;
        w_hi = 7'd31;
      end
      3'd4: begin
        w_lo = 7'd1;
        w_hi = 7'd12;
      end
      3'd5: begin
        w_lo = 7'd0;
        w_hi = 7'd99;
      end
      default: ;
    endcase
  end

  // 12 h correction overrides any edit of the hour in the same cycle
  always_ff @(posedge clk or posedge btn_reset) begin
    if (btn_reset) begin
      r_field[0] <= 7'd0;
      r_field[1] <= 7'd0;
      r_field[2] <= 7'd0;
      r_field[3] <= 7'd1;
      r_field[4] <= 7'd1;
      r_field[5] <= 7'd0;
    end else begin
      if (w_inc)
        r_field[r_cursor] <= (w_cur >= w_hi) ?
                             w_lo : w_cur + 7'd1;
      else if (w_dec)
        r_field[r_cursor] <= (w_cur <= w_lo) ?
                             w_hi : w_cur - 7'd1;
      if (w_fix12)
        r_field[2] <= 7'd12;
    end
  end

  always_ff @(posedge clk or posedge btn_reset) begin
    if (btn_reset)
      r_cursor <= 3'd0;
    else if (w_right)
      r_cursor <= (r_cursor == 3'd5) ?
                  3'd0 : r_cursor + 3'd1;
    else if (w_left)
      r_cursor <= (r_cursor == 3'd0) ?
                  3'd5 : r_cursor - 3'd1;
  end

  always_ff @(posedge clk or posedge btn_reset) begin
    if (btn_reset) begin
      r_esc_cur  <= 1'b0;
      r_esc_prev <= 1'b0;
      r_ini_cur  <= 1'b0;
      r_ini_prev <= 1'b0;
    end else begin
      r_esc_cur  <= escrib;
      r_esc_prev <= r_esc_cur;
      r_ini_cur  <= init_sw;
      r_ini_prev <= r_ini_cur;
    end
  end

  always_ff @(posedge clk or posedge btn_reset) begin
    if (btn_reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_ff @(posedge clk or posedge btn_reset) begin
    if (btn_reset)
      r_idx <= 3'd0;
    else if (r_state == S_IDLE)
      r_idx <= 3'd0;
    else if (r_state == S_WGAP && r_idx != 3'd5)
      r_idx <= r_idx + 3'd1;
  end

  always_comb begin
    w_next  = r_state;
    wr_req  = 1'b0;
    wr_addr = 8'd0;
    wr_data = 8'd0;
    case (r_state)
      S_IDLE: begin
        if (w_ini_rise)
          w_next = S_IREQ0;
        else if (w_esc_rise && sw_conf)
          w_next = S_WREQ;
      end
      S_WREQ: begin
        wr_req  = 1'b1;
        wr_addr = BASE_ADDR + {5'd0, r_idx};
        wr_data = w_bcd;
        if (wr_ack)
          w_next = S_WGAP;
      end
      S_WGAP: begin
        w_next = (r_idx == 3'd5) ? S_DONE : S_WREQ;
      end
      S_IREQ0: begin
        wr_req  = 1'b1;
        wr_addr = INIT_ADDR;
        wr_data = INIT_DATA0;
        if (wr_ack)
          w_next = S_IGAP;
      end
      S_IGAP: begin
        w_next = S_IREQ1;
      end
      S_IREQ1: begin
        wr_req  = 1'b1;
        wr_addr = INIT_ADDR;
        wr_data = INIT_DATA1;
        if (wr_ack)
          w_next = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule
